// File: rtl/sigma_mem_pkg.sv
// Shared constants, state encoding and helpers for the CPU/IOP memory port arbiter.
package sigma_mem_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 4;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_IOP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  function automatic logic [WAIT_W-1:0] wait_inc_sat(input logic [WAIT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between CPU and IOP requests.
// A tie goes to the IOP when it is starved, otherwise to the pointer-favoured side.
module mem_arb_select
  import sigma_mem_pkg::*;
#(
  parameter int IOP_MAX_WAIT = 4
) (
  input  logic              i_cpu_req,
  input  logic              i_iop_req,
  input  logic              i_ptr,
  input  logic [WAIT_W-1:0] i_wait,
  output logic              o_winner
);

  logic w_starved;

  assign w_starved = (i_wait == WAIT_W'(IOP_MAX_WAIT));

  always_comb begin
    o_winner = OWNER_CPU;
    if (i_cpu_req && i_iop_req) begin
      o_winner = w_starved ? OWNER_IOP : i_ptr;
    end else if (i_iop_req) begin
      o_winner = OWNER_IOP;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/IOP) arbiter in front of a single-port memory, 3-cycle access.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is CPU priority with IOP starvation guard.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no access in flight; sample requests and grant a winner
// ST_ACCESS | memory addressed by the winner; write strobe for writes
// ST_RESP   | ack pulse to the owner; requests ignored
module mem_port_arbiter
  import sigma_mem_pkg::*;
#(
  parameter int IOP_MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [15:31]      cpu_address,
  input  logic [0:31]       cpu_wdata,
  output logic              cpu_ack,
  output logic [0:31]       cpu_rdata,

  input  logic              iop_req,
  input  logic              iop_write,
  input  logic [15:31]      iop_address,
  input  logic [0:31]       iop_wdata,
  output logic              iop_ack,
  output logic [0:31]       iop_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,

  output logic              owner,
  output logic              busy
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;

  logic              w_any_req;
  logic              w_grant;
  logic              w_winner;
  logic              w_ptr;
  logic [WAIT_W-1:0] w_wait;

  logic              w_busy;
  logic              w_cpu_ack;
  logic              w_iop_ack;

  logic              r_owner;
  logic              r_mem_write_en;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data_in;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_iop_rdata;

  assign w_any_req = cpu_req | iop_req;
  assign w_grant   = (r_state == ST_IDLE) && w_any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  assign w_ptr  = r_ptr;
  assign w_wait = '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= OWNER_CPU;
    end else if (w_grant) begin
      r_ptr <= ~w_winner;
    end
  end
`else
  logic [WAIT_W-1:0] r_wait;

  assign w_ptr  = OWNER_CPU;
  assign w_wait = r_wait;

  // Counts CPU grants the IOP has lost while it was asking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= '0;
    end else if (w_grant) begin
      if (w_winner == OWNER_IOP) begin
        r_wait <= '0;
      end else if (iop_req) begin
        r_wait <= wait_inc_sat(r_wait);
      end
    end
  end
`endif

  mem_arb_select #(
    .IOP_MAX_WAIT (IOP_MAX_WAIT)
  ) u_select (
    .i_cpu_req (cpu_req),
    .i_iop_req (iop_req),
    .i_ptr     (w_ptr),
    .i_wait    (w_wait),
    .o_winner  (w_winner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_cpu_ack   = 1'b0;
    w_iop_ack   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_busy      = 1'b1;
        w_cpu_ack   = (r_owner == OWNER_CPU);
        w_iop_ack   = (r_owner == OWNER_IOP);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The write strobe is a register so reset kills it without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner        <= OWNER_CPU;
      r_mem_write_en <= 1'b0;
      r_mem_address  <= '0;
      r_mem_data_in  <= '0;
    end else if (w_grant) begin
      r_owner <= w_winner;
      if (w_winner == OWNER_IOP) begin
        r_mem_write_en <= iop_write;
        r_mem_address  <= iop_address;
        r_mem_data_in  <= iop_wdata;
      end else begin
        r_mem_write_en <= cpu_write;
        r_mem_address  <= cpu_address;
        r_mem_data_in  <= cpu_wdata;
      end
    end else begin
      r_mem_write_en <= 1'b0;
    end
  end

  // In ACCESS the strobe register doubles as the read/write flag of the access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rdata <= '0;
      r_iop_rdata <= '0;
    end else if ((r_state == ST_ACCESS) && !r_mem_write_en) begin
      if (r_owner == OWNER_IOP) begin
        r_iop_rdata <= mem_data_out;
      end else begin
        r_cpu_rdata <= mem_data_out;
      end
    end
  end

  assign cpu_ack      = w_cpu_ack;
  assign iop_ack      = w_iop_ack;
  assign busy         = w_busy;
  assign owner        = r_owner;
  assign cpu_rdata    = r_cpu_rdata;
  assign iop_rdata    = r_iop_rdata;
  assign mem_address  = r_mem_address;
  assign mem_write_en = r_mem_write_en;
  assign mem_data_in  = r_mem_data_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration and memory model.
module tb_mem_port_arbiter;

  localparam int MAXW  = 4;
  localparam int MEM_N = 131072;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req, cpu_write, iop_req, iop_write;
  logic [16:0] cpu_address, iop_address;
  logic [31:0] cpu_wdata, iop_wdata;
  logic        cpu_ack, iop_ack;
  logic [31:0] cpu_rdata, iop_rdata;
  logic [16:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_data_in, mem_data_out;
  logic        owner, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ack_cyc = 0;

  logic [31:0] mem     [0:MEM_N-1];
  logic [31:0] exp_mem [0:MEM_N-1];
  int          m_wait;
  bit          m_ptr;
  logic [31:0] exp_cpu_rdata, exp_iop_rdata;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign mem_data_out = mem[mem_address];
  always @(posedge clock) if (mem_write_en) mem[mem_address] <= mem_data_in;

  mem_port_arbiter #(.IOP_MAX_WAIT(MAXW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu_req      (cpu_req),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .iop_req      (iop_req),
    .iop_write    (iop_write),
    .iop_address  (iop_address),
    .iop_wdata    (iop_wdata),
    .iop_ack      (iop_ack),
    .iop_rdata    (iop_rdata),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .owner        (owner),
    .busy         (busy)
  );

  task automatic model_reset();
    m_wait = 0;
    m_ptr = 1'b0;
    exp_cpu_rdata = '0;
    exp_iop_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0;
    iop_req = 0; iop_write = 0; iop_address = '0; iop_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic set_cpu(input bit wr, input logic [16:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_write = wr; cpu_address = a; cpu_wdata = d;
  endtask

  task automatic set_iop(input bit wr, input logic [16:0] a, input logic [31:0] d);
    iop_req = 1; iop_write = wr; iop_address = a; iop_wdata = d;
  endtask

  // One full grant/access/response round from an IDLE cycle with at least one request up.
  task automatic do_round(output bit w);
    bit          wr;
    logic [16:0] a;
    logic [31:0] d;
    if (cpu_req && iop_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = m_ptr;
`else
      w = (m_wait == MAXW);
`endif
    end else begin
      w = iop_req;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    m_ptr = !w;
`else
    if (w) m_wait = 0;
    else if (iop_req && m_wait < 15) m_wait = m_wait + 1;
`endif
    wr = w ? iop_write : cpu_write;
    a  = w ? iop_address : cpu_address;
    d  = w ? iop_wdata : cpu_wdata;

    @(posedge clock); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL access_busy got=%b exp=1", busy); end
    checks++; if (owner !== w) begin failures++; $display("FAIL access_owner got=%b exp=%b", owner, w); end
    checks++; if (mem_write_en !== wr) begin failures++; $display("FAIL access_we got=%b exp=%b", mem_write_en, wr); end
    checks++; if (mem_address !== a) begin failures++; $display("FAIL access_addr got=%h exp=%h", mem_address, a); end
    checks++; if ({cpu_ack, iop_ack} !== 2'b00) begin failures++; $display("FAIL access_ack got=%b exp=00", {cpu_ack, iop_ack}); end
    if (wr) begin
      checks++; if (mem_data_in !== d) begin failures++; $display("FAIL access_wdata got=%h exp=%h", mem_data_in, d); end
    end

    @(posedge clock); #1;
    if (wr) exp_mem[a] = d;
    else if (w) exp_iop_rdata = exp_mem[a];
    else exp_cpu_rdata = exp_mem[a];
    checks++; if ({cpu_ack, iop_ack} !== (w ? 2'b01 : 2'b10)) begin failures++; $display("FAIL resp_ack got=%b exp=%b", {cpu_ack, iop_ack}, (w ? 2'b01 : 2'b10)); end
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL resp_we got=%b exp=0", mem_write_en); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL resp_busy got=%b exp=1", busy); end
    checks++; if (cpu_rdata !== exp_cpu_rdata) begin failures++; $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, exp_cpu_rdata); end
    checks++; if (iop_rdata !== exp_iop_rdata) begin failures++; $display("FAIL iop_rdata got=%h exp=%h", iop_rdata, exp_iop_rdata); end
    last_ack_cyc = cyc;
    if (w) iop_req = 0; else cpu_req = 0;

    @(posedge clock); #1;
    checks++; if ({cpu_ack, iop_ack, busy} !== 3'b000) begin failures++; $display("FAIL idle_ack_busy got=%b exp=000", {cpu_ack, iop_ack, busy}); end
    checks++; if (mem_address !== a) begin failures++; $display("FAIL idle_addr_hold got=%h exp=%h", mem_address, a); end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({owner, busy, cpu_ack, iop_ack, mem_write_en} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {owner, busy, cpu_ack, iop_ack, mem_write_en}); end
    checks++; if (mem_address !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    checks++; if (mem_data_in !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_data_in); end
    checks++; if (cpu_rdata !== '0 || iop_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", cpu_rdata, iop_rdata); end
  endtask

  task automatic test_cpu_read();
    bit w;
    int req_cyc;
    mem[5] = 32'h12345678; exp_mem[5] = 32'h12345678;
    set_cpu(0, 17'h00005, 32'h0);
    req_cyc = cyc + 1;
    do_round(w);
    checks++; if (w !== 1'b0 || cpu_rdata !== 32'h12345678) begin failures++; $display("FAIL cpu_read got=%h owner=%b exp=12345678 owner=0", cpu_rdata, w); end
    checks++; if (last_ack_cyc - req_cyc !== 1) begin failures++; $display("FAIL cpu_read_latency got=%0d exp=1 edges after sample", last_ack_cyc - req_cyc); end
  endtask

  task automatic test_iop_write();
    bit w;
    set_iop(1, 17'h00010, 32'hDEADBEEF);
    do_round(w);
    checks++; if (mem[17'h10] !== 32'hDEADBEEF) begin failures++; $display("FAIL iop_write_mem got=%h exp=deadbeef", mem[17'h10]); end
    set_cpu(0, 17'h00010, 32'h0);
    do_round(w);
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL readback got=%h exp=deadbeef", cpu_rdata); end
  endtask

  task automatic test_back_to_back();
    bit w;
    bit exp_w;
    int prev_ack;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (!cpu_req) set_cpu(1'($urandom_range(1)), 17'($urandom_range(63)), $urandom);
      if (!iop_req) set_iop(1'($urandom_range(1)), 17'($urandom_range(63)), $urandom);
      prev_ack = last_ack_cyc;
      do_round(w);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_w = (k % 2) == 1;
`else
      exp_w = (k % (MAXW + 1)) == MAXW;
`endif
      checks++; if (w !== exp_w) begin failures++; $display("FAIL grant_seq k=%0d got=%b exp=%b", k, w, exp_w); end
      if (k > 0) begin
        checks++; if (last_ack_cyc - prev_ack !== 3) begin failures++; $display("FAIL ack_spacing k=%0d got=%0d exp=3", k, last_ack_cyc - prev_ack); end
      end
    end
    cpu_req = 0; iop_req = 0;
  endtask

  task automatic test_random();
    bit w;
    for (int k = 0; k < 80; k++) begin
      if (!cpu_req && $urandom_range(1)) set_cpu(1'($urandom_range(1)), 17'($urandom_range(31)), $urandom);
      if (!iop_req && $urandom_range(1)) set_iop(1'($urandom_range(1)), 17'($urandom_range(31)), $urandom);
      if (cpu_req || iop_req) begin
        do_round(w);
      end else begin
        @(posedge clock); #1;
        checks++; if ({busy, cpu_ack, iop_ack, mem_write_en} !== 4'b0) begin failures++; $display("FAIL idle_quiet got=%b exp=0000", {busy, cpu_ack, iop_ack, mem_write_en}); end
      end
    end
    cpu_req = 0; iop_req = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_access();
    bit acked;
    mem[17'h20] = 32'hAAAA0001; exp_mem[17'h20] = 32'hAAAA0001;
    set_iop(1, 17'h00020, 32'h55555555);
    @(posedge clock); #1;
    checks++; if (mem_write_en !== 1'b1) begin failures++; $display("FAIL abort_we_pre got=%b exp=1", mem_write_en); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL abort_we_async got=%b exp=0", mem_write_en); end
    iop_req = 0;
    @(posedge clock); #1;
    checks++; if (mem[17'h20] !== exp_mem[17'h20]) begin failures++; $display("FAIL abort_mem got=%h exp=%h", mem[17'h20], exp_mem[17'h20]); end
    checks++; if ({owner, busy, cpu_ack, iop_ack, mem_write_en} !== 5'b0 || mem_address !== '0 || mem_data_in !== '0 || cpu_rdata !== '0 || iop_rdata !== '0) begin
      failures++; $display("FAIL abort_outputs ctrl=%b addr=%h wd=%h rd=%h/%h exp=all zero", {owner, busy, cpu_ack, iop_ack, mem_write_en}, mem_address, mem_data_in, cpu_rdata, iop_rdata);
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    acked = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (cpu_ack || iop_ack) acked = 1;
    end
    checks++; if (acked !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", acked); end
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B1 + 32'h1357;
      exp_mem[i] = mem[i];
    end
    model_reset();
    test_reset();
    test_cpu_read();
    test_iop_write();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter IOP_MAX_WAIT, default 4, the number of consecutive CPU grants an IOP request may lose before it is forced a grant (legal 1..15).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 SHALL have ports cpu_write (input, 1), cpu_address (input, 17, [15:31] word address) and cpu_wdata (input, 32, [0:31]); all stable while cpu_req is high.
REQ-006 SHALL have ports cpu_ack (output, 1, one-cycle completion pulse) and cpu_rdata (output, 32, read data).
REQ-007 SHALL have ports iop_req, iop_write, iop_address, iop_wdata, iop_ack and iop_rdata, identical in width and meaning to the CPU set.
REQ-008 SHALL have ports mem_address (output, 17), mem_write_en (output, 1), mem_data_in (output, 32) and mem_data_out (input, 32) to the single-port memory; memory read is combinational and memory write is synchronous.
REQ-009 SHALL have ports owner (output, 1; 0 = CPU, 1 = IOP) and busy (output, 1; high in ACCESS and RESP).

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS and RESP: IDLE goes to ACCESS when any req is high, otherwise stays in IDLE; ACCESS goes to RESP; RESP goes to IDLE.
REQ-011 SHALL, on IDLE->ACCESS, register the winner into owner and register its address, wdata and write into mem_address, mem_data_in and mem_write_en.
REQ-012 SHALL assert mem_write_en only during ACCESS and only for a write; mem_address and mem_data_in SHALL hold their values through RESP and IDLE.
REQ-013 SHALL capture mem_data_out into the owner's rdata at the end of ACCESS for reads; a write SHALL leave both rdata registers unchanged.
REQ-014 SHALL assert the owner's ack for exactly the RESP cycle; the fixed latency is req sampled in cycle N, ACCESS in N+1, ack in N+2.
REQ-015 SHALL treat a req still high in the IDLE cycle after RESP as a new request, so back-to-back accesses occur every 3 cycles.
REQ-016 SHALL ignore req and all request fields in ACCESS and RESP; the non-winning requester stays pending.
REQ-017 SHALL, in fixed-priority mode, grant CPU on a tie unless the IOP wait counter equals IOP_MAX_WAIT, in which case IOP wins.
REQ-018 SHALL increment the 4-bit saturating wait counter on each CPU grant while iop_req is high, and SHALL clear it on each IOP grant.
REQ-019 SHALL never assert cpu_ack and iop_ack in the same cycle.

Reset
REQ-020 SHALL, while reset_n is low, force state IDLE, owner 0, busy 0, both ack 0, mem_write_en 0, mem_address 0, mem_data_in 0, both rdata 0, wait counter 0 and round-robin pointer to CPU.
REQ-021 SHALL, on reset mid-access, deassert mem_write_en immediately (asynchronously) and SHALL NOT issue an ack for the aborted access.

Configuration
REQ-022 SHALL compile round-robin arbitration when MEM_ARB_ROUND_ROBIN_EN is defined: a tie goes to the pointer-favoured requester, the pointer moves to the other requester after every grant, and the wait counter is unused.
REQ-023 SHALL compile fixed priority with the starvation guard (REQ-017, REQ-018) when MEM_ARB_ROUND_ROBIN_EN is not defined.

Structure
REQ-024 SHALL place the FSM state encoding, ADDR_W=17, DATA_W=32 and the OWNER_CPU/OWNER_IOP constants in shared package sigma_mem_pkg.
REQ-025 SHALL factor winner selection into combinational sub-module mem_arb_select (inputs: both req, pointer, wait count; output: winner).

Verification
REQ-026 CPU read of address 17'h00005 holding 32'h12345678 -> cpu_ack high 2 cycles after req is sampled, cpu_rdata = 32'h12345678, owner = 0.
REQ-027 IOP write of 32'hDEADBEEF to 17'h00010 -> mem_write_en high for exactly 1 cycle, iop_ack 1 cycle later; a following CPU read of 17'h00010 returns 32'hDEADBEEF.
REQ-028 Both req held continuously in fixed mode with IOP_MAX_WAIT=4 -> grant sequence CPU,CPU,CPU,CPU,IOP repeating, with the wait counter clearing at each IOP grant.
REQ-029 Both req held continuously with MEM_ARB_ROUND_ROBIN_EN -> grants alternate CPU,IOP,CPU,IOP with acks 3 cycles apart.
REQ-030 reset_n dropped during an ACCESS write -> mem_write_en low the same cycle, no ack issued, the memory cell keeps its old value, and all outputs read 0.
